// File: rtl/mvb_slave_responder.sv
// MVB slave-side responder: matches master frames against a 16-entry port table, answers
// source ports with a delayed slave frame streamed from process-data RAM, flags sink ports.
module mvb_slave_responder #(
  parameter int unsigned REPLY_DELAY = 48,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        mf_valid,
  input  logic [15:0] mf_data,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_idx,
  input  logic [13:0] cfg_data,
  output logic        src_rd_en,
  output logic [7:0]  src_rd_addr,
  input  logic [15:0] src_rd_data,
  output logic        tx_start,
  output logic [4:0]  tx_words,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_done,
  output logic        tx_abort,
  output logic        sink_hit,
  output logic [3:0]  sink_port,
  output logic        mf_ignored
);

  localparam logic [9:0] DlyLoad  = 10'(REPLY_DELAY - 1);
  localparam logic [7:0] StallMax = 8'(STALL_LIMIT - 1);

  typedef enum logic [2:0] {StIdle, StMatch, StWait, StLoad, StSend, StFetch} state_e;
  state_e state_q, state_d;

  logic [13:0] table_q [16];
  logic        hit, hit_src, fcode_ok;
  logic [3:0]  hit_idx;
  logic [4:0]  len_dec;

  logic [3:0]  m_idx_q, word_q, sink_port_q;
  logic [4:0]  m_len_q, acc_q, words_q;
  logic        m_go_q, ign_q, sink_q, fresh_q, done_q, abort_q;
  logic [9:0]  dly_q;
  logic [7:0]  stall_q;
  logic [15:0] hold_q;
  logic        accept, last, stall_to;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 16; i++) table_q[i] <= '0;
    end else if (cfg_we) begin
      table_q[cfg_idx] <= cfg_data;
    end
  end

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    hit     = 1'b0;
    hit_src = 1'b0;
    hit_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (table_q[i][13] && (table_q[i][11:0] == mf_data[11:0])) begin
        hit     = 1'b1;
        hit_src = table_q[i][12];
        hit_idx = 4'(i);
      end
    end
  end

  assign fcode_ok = (mf_data[15:12] <= 4'd4);
  assign len_dec  = 5'd1 << mf_data[14:12];

  assign accept   = (state_q == StSend) && tx_ready;
  assign last     = accept && ((acc_q + 5'd1) == m_len_q);
  assign stall_to = (state_q == StSend) && !tx_ready && (stall_q == StallMax);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (mf_valid) state_d = StMatch;
      StMatch: begin
        if (!m_go_q)               state_d = StIdle;
        else if (REPLY_DELAY == 0) state_d = StLoad;
        else                       state_d = StWait;
      end
      StWait:  if (dly_q == '0) state_d = StLoad;
      StLoad:  state_d = StSend;
      StSend: begin
        if (last || stall_to) state_d = StIdle;
        else if (accept)      state_d = StFetch;
      end
      StFetch: state_d = StSend;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      m_idx_q     <= '0;
      m_len_q     <= '0;
      m_go_q      <= 1'b0;
      ign_q       <= 1'b0;
      sink_q      <= 1'b0;
      sink_port_q <= '0;
      dly_q       <= '0;
      word_q      <= '0;
      acc_q       <= '0;
      stall_q     <= '0;
      fresh_q     <= 1'b0;
      hold_q      <= '0;
      words_q     <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // The matched entry is captured here so later table writes cannot disturb this frame.
      if (state_q == StIdle && mf_valid) begin
        m_idx_q <= hit_idx;
        m_len_q <= len_dec;
        m_go_q  <= hit && hit_src && fcode_ok;
      end
      ign_q  <= mf_valid && ((state_q != StIdle) || !fcode_ok || !hit);
      sink_q <= mf_valid && (state_q == StIdle) && fcode_ok && hit && !hit_src;
      if (mf_valid && (state_q == StIdle) && fcode_ok && hit && !hit_src) sink_port_q <= hit_idx;

      if (state_q == StMatch)                    dly_q <= DlyLoad;
      else if (state_q == StWait && dly_q != '0) dly_q <= dly_q - 10'd1;

      if (state_q == StMatch) begin
        word_q <= '0;
        acc_q  <= '0;
      end else if (accept) begin
        word_q <= word_q + 4'd1;
        acc_q  <= acc_q + 5'd1;
      end

      if (state_q != StSend || accept) stall_q <= '0;
      else                             stall_q <= stall_q + 8'd1;

      // First SEND cycle passes RAM data through; later cycles replay the captured copy.
      fresh_q <= (state_q == StLoad) || (state_q == StFetch);
      if (fresh_q) hold_q <= src_rd_data;

      if (state_d == StLoad)      words_q <= m_len_q;
      else if (state_d == StIdle) words_q <= '0;

      done_q  <= last;
      abort_q <= stall_to;
    end
  end

  assign src_rd_en   = (state_q == StLoad) || (state_q == StFetch);
  assign src_rd_addr = src_rd_en ? {m_idx_q, word_q} : 8'h00;
  assign tx_start    = (state_q == StLoad);
  assign tx_words    = words_q;
  assign tx_valid    = (state_q == StSend);
  assign tx_data     = (state_q != StSend) ? 16'h0000 : (fresh_q ? src_rd_data : hold_q);
  assign tx_done     = done_q;
  assign tx_abort    = abort_q;
  assign sink_hit    = sink_q;
  assign sink_port   = sink_port_q;
  assign mf_ignored  = ign_q;

endmodule

// File: tb/tb_mvb_slave_responder.sv
// Directed plus randomized bench for mvb_slave_responder against a port-table/RAM model.
module tb_mvb_slave_responder;
  localparam int unsigned D  = 48;
  localparam int unsigned SL = 255;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        mf_valid = 1'b0;
  logic [15:0] mf_data = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [13:0] cfg_data = '0;
  logic        src_rd_en;
  logic [7:0]  src_rd_addr;
  logic [15:0] src_rd_data = '0;
  logic        tx_start;
  logic [4:0]  tx_words;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_done, tx_abort, sink_hit, mf_ignored;
  logic [3:0]  sink_port;
  logic [39:0] all_outs;

  mvb_slave_responder #(.REPLY_DELAY(D), .STALL_LIMIT(SL)) dut (
    .CLK(CLK), .RESET(RESET), .mf_valid(mf_valid), .mf_data(mf_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .tx_start(tx_start), .tx_words(tx_words), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_abort(tx_abort), .sink_hit(sink_hit),
    .sink_port(sink_port), .mf_ignored(mf_ignored)
  );

  assign all_outs = {src_rd_en, src_rd_addr, tx_start, tx_words, tx_data, tx_valid, tx_done,
                     tx_abort, sink_hit, sink_port, mf_ignored};

  always #5 CLK = ~CLK;

  logic [15:0] ram [256];
  always @(posedge CLK) if (src_rd_en) src_rd_data <= ram[src_rd_addr];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference port table.
  logic        tv [16];
  logic        ts [16];
  logic [11:0] ta [16];

  int start_t[$], start_w[$], vrise_t[$], done_t[$], abort_t[$], ign_t[$], sink_t[$], sink_p[$];
  logic [15:0] got[$];
  int acc_last = 0;
  int n_acc = 0;
  logic prev_valid = 1'b0, prev_acc = 1'b0;
  logic [15:0] prev_data = '0;

  int rdy_mode = 0;
  int stall_word = 0;
  int stall_left = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    start_t.delete(); start_w.delete(); vrise_t.delete(); done_t.delete();
    abort_t.delete(); ign_t.delete(); sink_t.delete(); sink_p.delete(); got.delete();
    n_acc = 0;
  endtask

  // Monitor, sampling between active edges.
  initial forever begin
    @(negedge CLK);
    if (RESET) begin
      if (tx_start) begin start_t.push_back(cyc); start_w.push_back(int'(tx_words)); end
      if (tx_valid && !prev_valid) vrise_t.push_back(cyc);
      if (prev_valid && !prev_acc) begin
        if (tx_valid) chk("hold_data", tx_data, prev_data);
        else          chk("drop_is_abort", tx_abort, 1);
      end
      if (tx_valid && tx_ready) begin got.push_back(tx_data); acc_last = cyc; n_acc++; end
      if (tx_done) done_t.push_back(cyc);
      if (tx_abort) abort_t.push_back(cyc);
      if (mf_ignored) ign_t.push_back(cyc);
      if (sink_hit) begin sink_t.push_back(cyc); sink_p.push_back(int'(sink_port)); end
      prev_valid = tx_valid;
      prev_acc   = tx_valid && tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // tx_ready driver: 0 always ready, 1 random, 2 stall on one word, 3 never ready.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = ($urandom_range(0, 3) != 0);
        2: if (n_acc == stall_word && stall_left > 0) begin
             tx_ready = 1'b0;
             stall_left--;
           end else tx_ready = 1'b1;
        default: tx_ready = 1'b0;
      endcase
    end
  end

  task automatic set_entry(input int idx, input logic v, input logic s, input logic [11:0] a);
    cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_data = {v, s, a};
    tick();
    cfg_we = 1'b0;
    tv[idx] = v; ts[idx] = s; ta[idx] = a;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin tv[i] = 1'b0; ts[i] = 1'b0; ta[i] = '0; end
  endtask

  // kind: 0 ignored, 1 sink, 2 source.
  task automatic predict(input logic [15:0] d, output int kind, output int idx, output int len);
    kind = 0; idx = 0; len = 0;
    if (d[15:12] <= 4) begin
      len = 1 << d[15:12];
      for (int i = 0; i < 16; i++)
        if (kind == 0 && tv[i] && ta[i] == d[11:0]) begin kind = ts[i] ? 2 : 1; idx = i; end
    end
  endtask

  task automatic send_mf(input logic [15:0] d, output int t);
    mf_valid = 1'b1; mf_data = d; t = cyc;
    tick();
    mf_valid = 1'b0; mf_data = '0;
  endtask

  task automatic wait_end(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (done_t.size() > 0 || abort_t.size() > 0) break;
      tick();
    end
    tick(); tick();
  endtask

  task automatic check_src(input int t, input int idx, input int len, input int exp_ign);
    chk("start_count", start_t.size(), 1);
    if (start_t.size() > 0) begin
      chk("start_time", start_t[0], t + 2 + D);
      chk("tx_words", start_w[0], len);
    end
    chk("valid_seen", vrise_t.size() > 0, 1);
    if (vrise_t.size() > 0) chk("first_valid", vrise_t[0], t + 3 + D);
    chk("word_count", got.size(), len);
    for (int i = 0; i < got.size() && i < len; i++) chk("word", got[i], ram[idx * 16 + i]);
    chk("done_count", done_t.size(), 1);
    if (done_t.size() > 0) chk("done_time", done_t[0], acc_last + 1);
    chk("abort_count", abort_t.size(), 0);
    chk("ign_count", ign_t.size(), exp_ign);
    chk("words_cleared", tx_words, 0);
  endtask

  task automatic run_frame(input logic [15:0] d);
    int kind, idx, len, t;
    predict(d, kind, idx, len);
    clear_logs();
    send_mf(d, t);
    if (kind == 2) begin
      wait_end(D + 2000);
      check_src(t, idx, len, 0);
    end else begin
      repeat (3) tick();
      chk("no_start", start_t.size(), 0);
      if (kind == 1) begin
        chk("sink_count", sink_t.size(), 1);
        chk("ign_none", ign_t.size(), 0);
        if (sink_t.size() > 0) begin
          chk("sink_time", sink_t[0], t + 1);
          chk("sink_port", sink_p[0], idx);
        end
      end else begin
        chk("ign_count", ign_t.size(), 1);
        chk("sink_none", sink_t.size(), 0);
        if (ign_t.size() > 0) chk("ign_time", ign_t[0], t + 1);
      end
    end
  endtask

  initial begin
    int t, t2, kind, idx, len;
    clear_model();
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) ram[8'h30 + i] = 16'h1111 * 16'(i + 1);

    repeat (3) tick();
    chk("reset_outs", all_outs, 0);
    RESET = 1'b1;
    repeat (2) tick();
    chk("idle_outs", all_outs, 0);

    // Source, F_code 2.
    set_entry(3, 1'b1, 1'b1, 12'h05A);
    run_frame(16'h205A);
    if (got.size() == 4) chk("tp_word3", got[3], 16'h4444);

    // Sink with priority over a higher-index source.
    set_entry(2, 1'b1, 1'b0, 12'h123);
    set_entry(7, 1'b1, 1'b1, 12'h123);
    run_frame(16'h0123);
    repeat (4) tick();
    chk("sink_port_held", sink_port, 2);

    // Ignored: bad F_code, unmatched address.
    run_frame(16'h5123);
    run_frame(16'h0ABC);

    // Second master frame during WAIT is dropped; first frame unaffected.
    clear_logs();
    send_mf(16'h205A, t);
    repeat (10) tick();
    send_mf(16'h0123, t2);
    wait_end(D + 200);
    check_src(t, 3, 4, 1);
    if (ign_t.size() > 0) chk("busy_ign_time", ign_t[0], t2 + 1);
    chk("busy_no_sink", sink_t.size(), 0);

    // 16-word frame with a 10-cycle stall on word 5.
    set_entry(5, 1'b1, 1'b1, 12'h7E1);
    rdy_mode = 2; stall_word = 5; stall_left = 10;
    run_frame(16'h47E1);

    // Stall timeout.
    rdy_mode = 3;
    clear_logs();
    send_mf(16'h47E1, t);
    wait_end(D + 600);
    chk("to_start", start_t.size(), 1);
    chk("to_words", got.size(), 0);
    chk("to_done", done_t.size(), 0);
    chk("to_abort", abort_t.size(), 1);
    if (abort_t.size() > 0 && vrise_t.size() > 0) chk("to_time", abort_t[0], vrise_t[0] + SL);
    chk("to_valid_low", tx_valid, 0);
    rdy_mode = 0;
    run_frame(16'h47E1);

    // Asynchronous reset during word 2.
    clear_logs();
    send_mf(16'h205A, t);
    for (int k = 0; k < D + 100; k++) begin
      if (tx_valid && n_acc == 2) break;
      tick();
    end
    chk("rst_in_word2", tx_valid && n_acc == 2, 1);
    #2;
    RESET = 1'b0;
    #1;
    chk("rst_async_outs", all_outs, 0);
    clear_logs();
    clear_model();
    repeat (3) tick();
    RESET = 1'b1;
    repeat (3) tick();
    chk("rst_no_done", done_t.size(), 0);
    chk("rst_no_abort", abort_t.size(), 0);
    set_entry(3, 1'b1, 1'b1, 12'h05A);
    run_frame(16'h205A);

    // Table write during WAIT.
    clear_logs();
    predict(16'h205A, kind, idx, len);
    send_mf(16'h205A, t);
    repeat (5) tick();
    set_entry(3, 1'b0, 1'b1, 12'h05A);
    wait_end(D + 200);
    check_src(t, idx, len, 0);
    run_frame(16'h205A);

    // Randomized table, frames and backpressure.
    rdy_mode = 1;
    for (int it = 0; it < 10; it++) begin
      for (int e = 8; e < 12; e++)
        set_entry(e, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  12'h100 + 12'($urandom_range(0, 3)));
      run_frame({4'($urandom_range(0, 5)), 12'h100 + 12'($urandom_range(0, 4))});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
